// File: rtl/hex_uart_logger.sv
// Captures every change of the CPU's 4-bit output register, queues it, and
// sends each value as one ASCII hex character on a UART 8N1 line.
module hex_uart_logger #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    out_val,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    // ------------------------------------------------------------------
    // Change detection
    // ------------------------------------------------------------------
    logic [3:0] prev_q;
    logic       init_q;
    logic       push;

    // The first cycle out of reset only captures a baseline.
    assign push = !init_q && (out_val != prev_q);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 4'h0;
            init_q <= 1'b1;
        end else begin
            prev_q <= out_val;
            init_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             pop;
    logic             wr_en;
    state_e           state_q;

    assign full  = (count_q == CNT_FULL);
    assign pop   = (state_q == IDLE) && (count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);

    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which
    // entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= out_val;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        byte_q;
    logic              tx_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            byte_q    <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    baud_q <= '0;
                    if (pop) begin
                        byte_q  <= hex_ascii(mem_q[rd_ptr_q]);
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= byte_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= byte_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_hex_uart_logger.sv
// Bench for hex_uart_logger: a queue-and-timeline model checked every cycle,
// plus directed scenarios with hand-computed frames, latencies and flags.
module tb_hex_uart_logger;

    localparam int C      = 4;
    localparam int DEPTH  = 4;
    localparam int BUDGET = 20 * C + 50;

    logic       clk;
    logic       rst;
    logic [3:0] out_val;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    hex_uart_logger #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_val   (out_val),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: queue of pending values plus the elapsed time of the frame on air
    // ------------------------------------------------------------------
    string      hexchars = "0123456789ABCDEF";
    logic [3:0] m_q[$];
    logic [3:0] m_prev;
    logic       m_init;
    logic       m_over;
    logic       m_active;
    int         m_el;
    logic [7:0] m_byte;
    logic       m_valid = 1'b0;

    function automatic logic model_tx();
        int pos;
        if (!m_active) return 1'b1;
        pos = m_el / C;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_byte[pos-1];
    endfunction

    initial begin
        logic       do_push;
        logic       do_pop;
        logic [3:0] v;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_prev   = 4'h0;
                m_init   = 1'b1;
                m_over   = 1'b0;
                m_active = 1'b0;
                m_el     = 0;
                m_byte   = 8'h00;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                do_push = !m_init && (out_val != m_prev);
                do_pop  = !m_active && (m_q.size() > 0);
                m_init  = 1'b0;
                m_prev  = out_val;
                if (m_active) begin
                    m_el++;
                    if (m_el == 10 * C) m_active = 1'b0;
                end
                if (do_pop) begin
                    v        = m_q.pop_front();
                    m_byte   = hexchars[v];
                    m_active = 1'b1;
                    m_el     = 0;
                end
                if (do_push) begin
                    if (m_q.size() < DEPTH) m_q.push_back(out_val);
                    else m_over = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_tx", 32'(tx), 32'(model_tx()));
                check("model_busy", 32'(busy), 32'(m_active));
                check("model_count", 32'(fifo_count), 32'(m_q.size()));
                check("model_overflow", 32'(overflow), 32'(m_over));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic do_reset(input logic [3:0] v);
        rst     = 1'b1;
        out_val = v;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Waits for a start bit, then samples each of the 10 bits mid-bit.
    // waited counts falling clock edges up to and including the start bit.
    task automatic rx_frame(output logic [9:0] bits, output int waited);
        bits   = '1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < BUDGET);
        if (tx !== 1'b0) begin
            check("rx_start_timeout", 32'(tx), 32'd0);
            return;
        end
        for (int i = 0; i < 10 * C; i++) begin
            if (i > 0) @(negedge clk);
            if (i % C == C / 2) bits[i / C] = tx;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < BUDGET);
        if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        int         w;
        rst     = 1'b1;
        out_val = 4'h0;

        // Reset hold: constant value after reset never pushes
        do_reset(4'h7);
        repeat (20) @(negedge clk);
        check("hold_tx", 32'(tx), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        check("hold_count", 32'(fifo_count), 32'd0);
        check("hold_overflow", 32'(overflow), 32'd0);

        // Single change 0 -> 5: latency, exact bit pattern, frame length
        do_reset(4'h0);
        out_val = 4'h5;
        @(negedge clk);
        check("single_tx_n", 32'(tx), 32'd1);
        check("single_cnt_n", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("single_tx_n1", 32'(tx), 32'd1);
        check("single_cnt_n1", 32'(fifo_count), 32'd1);
        rx_frame(f, w);
        check("single_fall_n2", 32'(w), 32'd1);
        check("single_bits", 32'(f), 32'(10'b1001101010));
        check("single_busy_39", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_busy_40", 32'(busy), 32'd0);

        // Letter encoding
        do_reset(4'h0);
        out_val = 4'hA;
        rx_frame(f, w);
        check("letter_A", 32'(f[8:1]), 32'h41);
        out_val = 4'hF;
        rx_frame(f, w);
        check("letter_F", 32'(f[8:1]), 32'h46);
        wait_idle();

        // Back-to-back frames with one idle cycle between them
        do_reset(4'h0);
        fork
            begin
                out_val = 4'h1;
                @(posedge clk);
                #1 out_val = 4'h2;
                @(posedge clk);
                #1 out_val = 4'h3;
                @(negedge clk);
                @(negedge clk);
                check("b2b_peak", 32'(fifo_count), 32'd2);
            end
            begin
                rx_frame(f, w);
                check("b2b_1", 32'(f[8:1]), 32'h31);
            end
        join
        rx_frame(f, w);
        check("b2b_2", 32'(f[8:1]), 32'h32);
        check("b2b_gap_2", 32'(w), 32'd2);
        rx_frame(f, w);
        check("b2b_3", 32'(f[8:1]), 32'h33);
        check("b2b_gap_3", 32'(w), 32'd2);
        check("b2b_overflow", 32'(overflow), 32'd0);
        wait_idle();

        // Overflow: seven changes on consecutive cycles
        do_reset(4'h0);
        for (int k = 1; k <= 7; k++) begin
            out_val = 4'(k);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_idle();
        for (int k = 2; k <= 5; k++) begin
            rx_frame(f, w);
            check("ovf_drain", 32'(f[8:1]), 32'h30 + 32'(k));
        end
        wait_idle();
        check("ovf_empty", 32'(fifo_count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during DATA bit 3 with a full FIFO and overflow set
        do_reset(4'h0);
        for (int k = 1; k <= 7; k++) begin
            out_val = 4'(k);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        repeat (12) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_tx", 32'(tx), 32'd1);
        check("mid_busy_clr", 32'(busy), 32'd0);
        check("mid_count", 32'(fifo_count), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 out_val = 4'hC;
        rx_frame(f, w);
        check("mid_after", 32'(f[8:1]), 32'h43);
        check("mid_after_fall", 32'(w), 32'd3);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_uart_logger.md
Name: hex_uart_logger

Overview:
- Sits directly downstream of the CPU's 4-bit output register (HEX).
- Detects every change of the output value and buffers it in a small FIFO.
- Transmits each buffered value as one ASCII hex character ('0'-'9', 'A'-'F') over a UART 8N1 serial line.
- Lets a host capture program output without watching the 7-segment display.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit; minimum 2.
- FIFO_DEPTH, 4, FIFO entries of 4 bits; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; same undivided clock that feeds the CPU before HLT gating.
- rst  input  1  reset.
- out_val  input  4  CPU output register value; synchronous to clk.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is being transmitted.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of entries held in the FIFO.
- overflow  output  1  sticky; set when a change is dropped because the FIFO is full.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values, sampled at the next clk edge with rst=1:
  - tx=1, busy=0, fifo_count=0, overflow=0.
  - FIFO pointers = 0, FSM = IDLE, prev register = 0, init flag = 1.
- Change detection:
  - prev holds out_val from the previous cycle.
  - First cycle after reset (init=1): load prev, clear init, no push.
  - Afterwards, when out_val != prev: push out_val, and update prev.
  - A value held constant generates no further pushes.
  - A→B→A over consecutive cycles generates two pushes.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Push and pop in the same cycle are both honoured.
  - Full, push, no pop: the new value is dropped, overflow is set to 1 and stays 1 until reset, count is unchanged.
  - Full, push, pop together: both occur and count stays at FIFO_DEPTH.
  - Empty, pop request: never issued.
- Encoding: v<10 → 8'h30+v; v>=10 → 8'h37+v (so 10 → 'A' = 8'h41).
- Transmitter FSM:
  - IDLE:
    - tx=1, busy=0.
    - If fifo_count>0: pop the head, latch its encoded byte, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA:
    - tx=byte[idx] for CLKS_PER_BIT cycles each, LSB first.
    - After idx 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy=1 in START, DATA and STOP.
  - Back-to-back frames: IDLE lasts exactly one cycle between a STOP and the next START.
- Latency, with the change visible on out_val in cycle N:
  - Push at the end of N.
  - fifo_count increments in N+1; pop in N+1.
  - tx falls in N+2.
  - Frame length = 10*CLKS_PER_BIT cycles.
- Reset mid-frame: tx returns to 1 on the reset edge and the frame is abandoned. FIFO contents and overflow are cleared.
- HLT: when the CPU halts, out_val stays constant. The logger keeps running on the ungated clk and drains the FIFO.

Test Plan:
- Reset hold: rst=1 for 3 cycles with out_val=4'h7, release, hold 4'h7 → no push, tx stays 1, fifo_count=0, busy=0.
- Single change (CLKS_PER_BIT=4): out_val 0→5 at cycle N → tx falls at N+2; bit sequence 0,1,0,1,0,1,1,0,0,1 (start, 8'h35 LSB first, stop), each bit held 4 cycles; busy drops after 40 cycles.
- Letter encoding: out_val 0→A, then A→F after the first frame completes → received bytes 8'h41 then 8'h46.
- Back-to-back: changes 1,2,3 on consecutive cycles → fifo_count peaks at 2; frames '1','2','3' are sent with exactly one idle cycle between stop and next start; no overflow.
- Overflow (FIFO_DEPTH=4): seven changes on consecutive cycles during the first frame → first value transmitted and four stored (fifo_count=4), last two dropped; overflow=1 and remains 1 after the FIFO drains.
- Reset mid-frame: assert rst during DATA bit 3 → next cycle tx=1, busy=0, fifo_count=0, overflow=0; a subsequent change is transmitted normally.
